// File: rtl/traffic_multi_if.sv
// Signal bundle between the traffic_multi controller and its environment.
// master = controller side, slave = sensor/lamp side. Preemption signals exist only with TRAFFIC_PREEMPT_EN.
interface traffic_multi_if #(
  parameter int N_DIR = 4
);
  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  logic [N_DIR-1:0]   sensor;
  logic [3*N_DIR-1:0] lights;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;

`ifdef TRAFFIC_PREEMPT_EN
  logic               emerg_req;
  logic [IDX_W-1:0]   emerg_dir;

  modport master (
    input  sensor, emerg_req, emerg_dir,
    output lights, grant_idx, busy
  );

  modport slave (
    output sensor, emerg_req, emerg_dir,
    input  lights, grant_idx, busy
  );
`else
  modport master (
    input  sensor,
    output lights, grant_idx, busy
  );

  modport slave (
    output sensor,
    input  lights, grant_idx, busy
  );
`endif
endinterface

// File: rtl/traffic_multi.sv
// Round-robin multi-approach traffic light controller: IDLE/GREEN/YELLOW/ALLRED phases.
// Optional emergency preemption enabled by defining TRAFFIC_PREEMPT_EN.
module traffic_multi #(
  parameter int N_DIR      = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  traffic_multi_if.master bus
);
  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [IDX_W:0]   N_DIR_W     = (IDX_W + 1)'(N_DIR);
  localparam logic [IDX_W-1:0] LAST_RST    = IDX_W'(N_DIR - 1);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] last_grant_reg, last_grant_next;

  logic [N_DIR-1:0]   grant_onehot;
  logic [2*N_DIR-1:0] sensor_dbl;
  logic [2*N_DIR-1:0] sensor_rot;
  logic [IDX_W-1:0]   rr_off;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   rr_sel;
  logic               any_req;
  logic               other_req;

  logic               emerg_act;
  logic [IDX_W-1:0]   emerg_dir_int;
  logic               arb_go;
  logic [IDX_W-1:0]   arb_pick;
  logic               preempt_away;
  logic               preempt_hold;

`ifdef TRAFFIC_PREEMPT_EN
  assign emerg_act     = bus.emerg_req;
  assign emerg_dir_int = bus.emerg_dir;
`else
  assign emerg_act     = 1'b0;
  assign emerg_dir_int = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_DIR; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  assign any_req   = |bus.sensor;
  assign other_req = |(bus.sensor & ~grant_onehot);

  // Doubling the request vector turns the wrap-around scan into a plain shift.
  assign sensor_dbl = {bus.sensor, bus.sensor};
  assign sensor_rot = sensor_dbl >> ({1'b0, last_grant_reg} + 1'b1);

  always_comb begin
    rr_off = '0;
    for (int k = N_DIR - 1; k >= 0; k--) begin
      if (sensor_rot[k]) rr_off = IDX_W'(k);
    end
  end

  always_comb begin
    rr_sum = {1'b0, last_grant_reg} + 1'b1 + {1'b0, rr_off};
    if (rr_sum >= N_DIR_W) rr_sum = rr_sum - N_DIR_W;
    rr_sel = rr_sum[IDX_W-1:0];
  end

  assign arb_go       = emerg_act | any_req;
  assign arb_pick     = emerg_act ? emerg_dir_int : rr_sel;
  assign preempt_away = emerg_act & (grant_reg != emerg_dir_int);
  assign preempt_hold = emerg_act & (grant_reg == emerg_dir_int);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      grant_reg      <= '0;
      last_grant_reg <= LAST_RST;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (arb_go) begin
          state_next      = GREEN;
          timer_next      = GREEN_LOAD;
          grant_next      = arb_pick;
          last_grant_next = arb_pick;
        end
      end
      GREEN: begin
        // Once the minimum has elapsed, green is only released to a competing request.
        if (preempt_away) begin
          state_next = YELLOW;
          timer_next = YELLOW_LOAD;
        end else if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else if (other_req && !preempt_hold) begin
          state_next = YELLOW;
          timer_next = YELLOW_LOAD;
        end
      end
      YELLOW: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else begin
          state_next = ALLRED;
          timer_next = ALLRED_LOAD;
        end
      end
      ALLRED: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else if (arb_go) begin
          state_next      = GREEN;
          timer_next      = GREEN_LOAD;
          grant_next      = arb_pick;
          last_grant_next = arb_pick;
        end else begin
          state_next = IDLE;
          timer_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Lamp decode depends only on registered state, so only one approach can be non-red.
  generate
    for (gi = 0; gi < N_DIR; gi++) begin : g_lamp
      assign bus.lights[3*gi +: 3] =
        !grant_onehot[gi]     ? 3'b100 :
        (state_reg == GREEN)  ? 3'b001 :
        (state_reg == YELLOW) ? 3'b010 : 3'b100;
    end
  endgenerate

  assign bus.grant_idx = ((state_reg == GREEN) || (state_reg == YELLOW)) ? grant_reg : '0;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_traffic_multi.sv
// Scoreboard bench for traffic_multi: stimulus queues expected per-cycle lamp states,
// a negedge monitor pops and compares them.
module tb_traffic_multi;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;

  always #5 if (clk_en) clk = ~clk;

  traffic_multi_if #(.N_DIR(N)) bus ();

  traffic_multi #(
    .N_DIR(N), .GREEN_CYC(8), .YELLOW_CYC(3), .ALLRED_CYC(1), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct packed {
    logic [3*N-1:0] lights;
    logic           busy;
    logic [IW-1:0]  gidx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int pending = 0;

  // kind: 0 idle, 1 green, 2 yellow, 3 all-red
  function automatic exp_t mk(int kind, int idx);
    exp_t e;
    e.lights = {N{3'b100}};
    if (kind == 1) e.lights[3*idx +: 3] = 3'b001;
    if (kind == 2) e.lights[3*idx +: 3] = 3'b010;
    e.busy = (kind != 0);
    e.gidx = (kind == 1 || kind == 2) ? IW'(idx) : '0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic seg(int n, int kind, int idx);
    for (int i = 0; i < n; i++) q.push_back(mk(kind, idx));
    pending += n;
  endtask

  task automatic flush();
    repeat (pending) @(negedge clk);
    #1;
    pending = 0;
  endtask

  task automatic chk_reset_now(string tag);
    chk({tag, "_lights"}, 32'(bus.lights), 32'h924);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_gidx"}, 32'(bus.grant_idx), 32'h0);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    chk_reset_now(tag);
    seg(2, 0, 0);
    flush();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int nonred;
    nonred = 0;
    for (int i = 0; i < N; i++)
      if (bus.lights[3*i +: 3] !== 3'b100) nonred++;
    chk("single_nonred", 32'(nonred <= 1), 32'h1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("lights", 32'(bus.lights), 32'(e.lights));
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("grant_idx", 32'(bus.grant_idx), 32'(e.gidx));
      $display("cycle t=%0t sensor=%b lights=%h busy=%0d gidx=%0d", $time,
               bus.sensor, bus.lights, bus.busy, bus.grant_idx);
    end
  end

  initial begin
    bus.sensor = '0;
`ifdef TRAFFIC_PREEMPT_EN
    bus.emerg_req = 1'b0;
    bus.emerg_dir = '0;
`endif
    // Asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #1 chk_reset_now("rst_noclk");
    clk_en = 1'b1;
    seg(2, 0, 0);
    flush();
    rst = 1'b0;
    seg(2, 0, 0);
    flush();

    // Single requester: green next edge, held indefinitely
    bus.sensor = 4'b0001;
    seg(50, 1, 0);
    flush();

    // Two requesters 0 and 2
    do_reset("rst_a");
    bus.sensor = 4'b0101;
    seg(8, 1, 0); seg(3, 2, 0); seg(1, 3, 0); seg(8, 1, 2);
    flush();

    // All four requesters: full round-robin rotation
    do_reset("rst_b");
    bus.sensor = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      seg(8, 1, g); seg(3, 2, g); seg(1, 3, 0);
    end
    seg(8, 1, 0);
    flush();

    // Reset during 2nd yellow cycle of approach 1, release with 1010
    do_reset("rst_c");
    bus.sensor = 4'b0011;
    seg(8, 1, 0); seg(3, 2, 0); seg(1, 3, 0); seg(8, 1, 1); seg(1, 2, 1);
    flush();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_now("rst_midyellow");
    bus.sensor = 4'b1010;
    seg(2, 0, 0);
    flush();
    rst = 1'b0;
    seg(8, 1, 1); seg(3, 2, 1); seg(1, 3, 0); seg(8, 1, 3);
    flush();

    // Own sensor drop keeps green; sensor drop in yellow does not shorten it
    do_reset("rst_d");
    bus.sensor = 4'b0001;
    seg(20, 1, 0);
    flush();
    bus.sensor = 4'b0000;
    seg(10, 1, 0);
    flush();
    bus.sensor = 4'b0100;
    seg(1, 2, 0);
    flush();
    bus.sensor = 4'b0000;
    seg(2, 2, 0); seg(1, 3, 0); seg(3, 0, 0);
    flush();

`ifdef TRAFFIC_PREEMPT_EN
    // Preemption of approach 0 in its 2nd green cycle toward approach 3
    do_reset("rst_e");
    bus.sensor = 4'b0001;
    seg(2, 1, 0);
    flush();
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 2'd3;
    seg(3, 2, 0); seg(1, 3, 0); seg(12, 1, 3);
    flush();
    bus.emerg_req = 1'b0;
    seg(3, 2, 3); seg(1, 3, 0); seg(2, 1, 0);
    flush();
`endif

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
